// File: rtl/opbuf_pkg.sv
// Shared types and helpers for the operand matrix buffer: state encoding,
// matrix dimension derivation and element indexing.
package opbuf_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Flat bank index of element k of vector vec (row vec, or column vec in column mode).
    function automatic int elem_index(input int vec, input int k, input logic col_mode,
                                      input int dim);
        return col_mode ? (k * dim + vec) : (vec * dim + k);
    endfunction

endpackage

// File: rtl/opbuf_bank.sv
// One storage bank of DEPTH elements with a write port, a synchronous clear
// and a flat view of every element for the read-side mux.
module opbuf_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        clr,
    output logic [DEPTH*DATA_WIDTH-1:0] data
);

    logic [DEPTH*DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[int'(wr_addr) * DATA_WIDTH +: DATA_WIDTH] <= wr_data;
        end else if (clr) begin
            mem <= '0;
        end
    end

    assign data = mem;

endmodule

// File: rtl/operand_matrix_buffer.sv
// Ping-pong operand store streaming a square matrix by rows or columns.
// Optional feature macro: OPBUF_CLEAR_ON_COMMIT_EN (zero the new fill bank on commit).
module operand_matrix_buffer
    import opbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  commit_i,
    input  logic                  start_i,
    input  logic                  col_mode_i,
    input  logic                  rd_ready_i,
    output logic                  rd_valid_o,
    output logic [BUS_WIDTH-1:0]  rd_data_o,
    output logic                  rd_last_o,
    output logic                  pend_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    localparam int MAX_DIM = max_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int DEPTH   = MAX_DIM * MAX_DIM;
    localparam int IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(MAX_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                      state, state_next;
    logic                        col_mode, col_mode_next;
    logic [IDX_W-1:0]            vec_idx, vec_idx_next;
    logic                        fill_bank, read_bank, pend, ovf;
    logic                        is_last, rel, commit_ok, wr_ok;
    logic [1:0]                  bank_wr, bank_clr;
    logic [DEPTH*DATA_WIDTH-1:0] bank_data [2];
    logic [DEPTH*DATA_WIDTH-1:0] read_flat;

    assign rd_valid_o = (state == STREAM);
    assign is_last    = (vec_idx == LAST_IDX);
    assign rel        = rd_valid_o && rd_ready_i && is_last;
    // A release on this edge frees the read side, so a same-cycle commit is taken.
    assign commit_ok  = commit_i && (!pend || rel);
    assign wr_ok      = wr_en_i && (wr_addr_i <= LAST_ADDR);

    assign bank_wr[0] = wr_ok && !fill_bank;
    assign bank_wr[1] = wr_ok && fill_bank;
`ifdef OPBUF_CLEAR_ON_COMMIT_EN
    assign bank_clr[0] = commit_ok && fill_bank;
    assign bank_clr[1] = commit_ok && !fill_bank;
`else
    assign bank_clr    = 2'b00;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        opbuf_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DEPTH     (DEPTH)
        ) u_bank (
            .clk    (clk),
            .rst    (rst_i),
            .wr_en  (bank_wr[b]),
            .wr_addr(wr_addr_i),
            .wr_data(wr_data_i),
            .clr    (bank_clr[b]),
            .data   (bank_data[b])
        );
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            fill_bank <= 1'b0;
            read_bank <= 1'b1;
            pend      <= 1'b0;
            ovf       <= 1'b0;
        end else if (commit_ok) begin
            read_bank <= fill_bank;
            fill_bank <= ~fill_bank;
            pend      <= 1'b1;
        end else begin
            if (commit_i) ovf <= 1'b1;
            if (rel)      pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            col_mode <= 1'b0;
            vec_idx  <= '0;
        end else begin
            state    <= state_next;
            col_mode <= col_mode_next;
            vec_idx  <= vec_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        col_mode_next = col_mode;
        vec_idx_next  = vec_idx;
        case (state)
            IDLE: begin
                if (start_i && pend) begin
                    state_next    = STREAM;
                    col_mode_next = col_mode_i;
                    vec_idx_next  = '0;
                end
            end
            STREAM: begin
                if (rd_ready_i) begin
                    if (is_last) state_next = IDLE;
                    else         vec_idx_next = vec_idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign read_flat = read_bank ? bank_data[1] : bank_data[0];

    always_comb begin
        rd_data_o = '0;
        if (rd_valid_o) begin
            for (int k = 0; k < MAX_DIM; k++) begin
                rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
                    read_flat[elem_index(int'(vec_idx), k, col_mode, MAX_DIM)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_last_o = rd_valid_o && is_last;
    assign pend_o    = pend;
    assign busy_o    = rd_valid_o;
    assign ovf_o     = ovf;

endmodule

// File: tb/tb_operand_matrix_buffer.sv
// Scoreboard bench for operand_matrix_buffer: a matrix-level model predicts
// streamed vectors and flag behaviour; a negedge monitor compares the DUT.
module tb_operand_matrix_buffer;

    localparam int DIM = 4;
    localparam int N   = DIM * DIM;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [7:0]  wr_addr_i = '0;
    logic [7:0]  wr_data_i = '0;
    logic        commit_i = 1'b0;
    logic        start_i = 1'b0;
    logic        col_mode_i = 1'b0;
    logic        rd_ready_i = 1'b0;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic        rd_last_o;
    logic        pend_o;
    logic        busy_o;
    logic        ovf_o;

    operand_matrix_buffer dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .commit_i  (commit_i),
        .start_i   (start_i),
        .col_mode_i(col_mode_i),
        .rd_ready_i(rd_ready_i),
        .rd_valid_o(rd_valid_o),
        .rd_data_o (rd_data_o),
        .rd_last_o (rd_last_o),
        .pend_o    (pend_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Matrix-level model
    logic [7:0]  m_mem [2][N];
    int          m_fill, m_rbank, m_remaining;
    bit          m_pend, m_stream, m_ovf;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) m_mem[b][i] = 8'h00;
        m_fill = 0; m_rbank = 1; m_remaining = 0;
        m_pend = 0; m_stream = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] matrix_vec(input int bank, input int v, input bit col);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < DIM; k++)
            r[k*8 +: 8] = col ? m_mem[bank][k*DIM + v] : m_mem[bank][v*DIM + k];
        return r;
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit pre_stream, pre_pend, rel;
        int pre_rbank;
        pre_stream = m_stream; pre_pend = m_pend; pre_rbank = m_rbank;
        rel = pre_stream && rd_ready_i && (m_remaining == 1);
        if (pre_stream && rd_ready_i) begin
            m_remaining--;
            if (m_remaining == 0) m_stream = 0;
        end
        if (wr_en_i && wr_addr_i < N) m_mem[m_fill][wr_addr_i] = wr_data_i;
        m_pend = rel ? 1'b0 : pre_pend;
        if (commit_i) begin
            if (!m_pend) begin
                m_rbank = m_fill;
                m_fill  = 1 - m_fill;
                m_pend  = 1;
`ifdef OPBUF_CLEAR_ON_COMMIT_EN
                for (int i = 0; i < N; i++) m_mem[m_fill][i] = 8'h00;
`endif
            end else begin
                m_ovf = 1;
            end
        end
        if (start_i && !pre_stream && pre_pend) begin
            m_stream = 1;
            m_remaining = DIM;
            for (int v = 0; v < DIM; v++) exp_q.push_back(matrix_vec(pre_rbank, v, col_mode_i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        wr_en_i = 0; commit_i = 0; start_i = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            chk("valid", {31'b0, rd_valid_o}, {31'b0, m_stream});
            chk("busy", {31'b0, busy_o}, {31'b0, m_stream});
            chk("pend", {31'b0, pend_o}, {31'b0, m_pend});
            chk("ovf", {31'b0, ovf_o}, {31'b0, m_ovf});
            if (rd_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vector", rd_data_o, 32'hxxxx_xxxx);
                end else begin
                    chk("data", rd_data_o, exp_q[0]);
                    chk("last", {31'b0, rd_last_o}, {31'b0, m_remaining == 1});
                    if (rd_ready_i) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_data", rd_data_o, 32'h0);
                chk("idle_last", {31'b0, rd_last_o}, 32'h0);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1;
        wr_en_i = 0; commit_i = 0; start_i = 0;
        #1;
        model_reset();
        chk("rst_valid", {31'b0, rd_valid_o}, 32'h0);
        chk("rst_data", rd_data_o, 32'h0);
        chk("rst_last", {31'b0, rd_last_o}, 32'h0);
        chk("rst_pend", {31'b0, pend_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_ovf", {31'b0, ovf_o}, 32'h0);
        #1;
        rst_i = 0;
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        wr_en_i = 1; wr_addr_i = 8'(addr); wr_data_i = data;
        step();
    endtask

    task automatic do_commit();
        commit_i = 1;
        step();
    endtask

    task automatic do_start(input bit col);
        start_i = 1; col_mode_i = col;
        step();
    endtask

    task automatic drain();
        rd_ready_i = 1;
        for (int i = 0; i < 40 && m_stream; i++) step();
        step();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("drain_busy", {31'b0, busy_o}, 32'h0);
    endtask

    initial begin
        do_reset();
        mon_en = 1;

        // Row mode
        for (int i = 0; i < N; i++) wr(i, 8'(i + 1));
        do_commit();
        rd_ready_i = 1;
        do_start(0);
        drain();

        // Column mode with ready toggling every cycle
        for (int i = 0; i < N; i++) wr(i, 8'(i + 1));
        do_commit();
        do_start(1);
        for (int c = 0; c < 12; c++) begin
            rd_ready_i = c[0];
            step();
        end
        drain();

        // Ping-pong: fill other bank during stream, commit on last handshake
        for (int i = 0; i < N; i++) wr(i, 8'($urandom));
        do_commit();
        rd_ready_i = 0;
        do_start(0);
        for (int i = 0; i < N; i++) wr(i, 8'hAA);
        rd_ready_i = 1;
        for (int i = 0; i < 20 && m_stream; i++) begin
            commit_i = (m_remaining == 1);
            step();
        end
        chk("pp_ovf", {31'b0, ovf_o}, 32'h0);
        chk("pp_pend", {31'b0, pend_o}, 32'h1);
        do_start(0);
        drain();

        // Refused commit and out-of-range write
        for (int i = 0; i < N; i++) wr(i, 8'($urandom));
        wr(16, 8'h5A);
        wr(200, 8'hC3);
        do_commit();
        for (int i = 0; i < N; i++) wr(i, 8'($urandom));
        do_commit();
        chk("refused_ovf", {31'b0, ovf_o}, 32'h1);
        do_start(1);
        drain();

        // Stale vs cleared fill bank
        for (int i = 0; i < N; i++) wr(i, 8'($urandom_range(1, 255)));
        do_commit();
        do_start(0);
        drain();
        wr(0, 8'h77);
        do_commit();
        do_start(0);
        drain();

        // Reset mid-stream after the first vector
        for (int i = 0; i < N; i++) wr(i, 8'($urandom_range(1, 255)));
        do_commit();
        rd_ready_i = 0;
        do_start(0);
        rd_ready_i = 1;
        step();
        rd_ready_i = 0;
        do_reset();
        step();
        wr(5, 8'h3C);
        do_commit();
        do_start(1);
        drain();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            wr_en_i    = 1'($urandom);
            wr_addr_i  = 8'($urandom_range(0, 19));
            wr_data_i  = 8'($urandom);
            commit_i   = ($urandom_range(0, 11) == 0);
            start_i    = ($urandom_range(0, 5) == 0);
            col_mode_i = 1'($urandom);
            rd_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
